// File: rtl/ub_host_loader.sv
// Host-to-unified-buffer ingress loader: packs a valid/ready byte stream into 2x2 tiles
// (4 lanes) and issues one registered write per tile starting at a commanded base address.
module ub_host_loader #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 13,
   parameter int MEM_SIZE = 32,
   parameter int TILES_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [TILES_W-1:0] num_tiles,
   input  logic              abort,
   input  logic              host_valid,
   input  logic [DATA_W-1:0] host_data,
   output logic              host_ready,
   output logic              ub_wr_en,
   output logic [ADDR_W-1:0] ub_wr_addr,
   output logic [DATA_W-1:0] ub_wr_d0,
   output logic [DATA_W-1:0] ub_wr_d1,
   output logic [DATA_W-1:0] ub_wr_d2,
   output logic [DATA_W-1:0] ub_wr_d3,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [TILES_W-1:0]  tiles_q, tiles_d;
   logic [1:0]          byte_cnt_q, byte_cnt_d;
   logic [DATA_W-1:0]   stage0_q, stage0_d;
   logic [DATA_W-1:0]   stage1_q, stage1_d;
   logic [DATA_W-1:0]   stage2_q, stage2_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   lane0_q, lane0_d;
   logic [DATA_W-1:0]   lane1_q, lane1_d;
   logic [DATA_W-1:0]   lane2_q, lane2_d;
   logic [DATA_W-1:0]   lane3_q, lane3_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic [ADDR_W:0]     end_addr;
   logic                range_bad;
   logic                accept;

   // One extra bit on the end address so a transfer near the top cannot wrap and pass the check.
   assign end_addr  = {1'b0, base_addr}
                    + ({{(ADDR_W + 1 - TILES_W){1'b0}}, num_tiles} << 2);
   assign range_bad = end_addr > (ADDR_W + 1)'(MEM_SIZE);
   assign accept    = host_valid && (state_q == S_RECV);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      tiles_d    = tiles_q;
      byte_cnt_d = byte_cnt_q;
      stage0_d   = stage0_q;
      stage1_d   = stage1_q;
      stage2_d   = stage2_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      lane0_d    = lane0_q;
      lane1_d    = lane1_q;
      lane2_d    = lane2_q;
      lane3_d    = lane3_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      if (abort) begin
         // A write already on the strobe completes; anything partial is dropped silently.
         state_d    = S_IDLE;
         ptr_d      = '0;
         tiles_d    = '0;
         byte_cnt_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (num_tiles == '0) begin
                     done_d = 1'b1;
                  end else if (range_bad) begin
                     err_d = 1'b1;
                  end else begin
                     ptr_d      = base_addr;
                     tiles_d    = num_tiles;
                     byte_cnt_d = '0;
                     state_d    = S_RECV;
                  end
               end
            end
            S_RECV: begin
               if (accept) begin
                  unique case (byte_cnt_q)
                     2'd0: stage0_d = host_data;
                     2'd1: stage1_d = host_data;
                     2'd2: stage2_d = host_data;
                     2'd3: begin
                        // Lanes only update on entry to WRITE so they stay stable between tiles.
                        lane0_d   = stage0_q;
                        lane1_d   = stage1_q;
                        lane2_d   = stage2_q;
                        lane3_d   = host_data;
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        state_d   = S_WRITE;
                     end
                     default: ;
                  endcase
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
            S_WRITE: begin
               ptr_d   = ptr_q + ADDR_W'(4);
               tiles_d = tiles_q - TILES_W'(1);
               if (tiles_q == TILES_W'(1)) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_RECV;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         tiles_q    <= '0;
         byte_cnt_q <= '0;
         stage0_q   <= '0;
         stage1_q   <= '0;
         stage2_q   <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         lane0_q    <= '0;
         lane1_q    <= '0;
         lane2_q    <= '0;
         lane3_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         tiles_q    <= tiles_d;
         byte_cnt_q <= byte_cnt_d;
         stage0_q   <= stage0_d;
         stage1_q   <= stage1_d;
         stage2_q   <= stage2_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         lane0_q    <= lane0_d;
         lane1_q    <= lane1_d;
         lane2_q    <= lane2_d;
         lane3_q    <= lane3_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign host_ready = (state_q == S_RECV);
   assign busy       = (state_q != S_IDLE);
   assign ub_wr_en   = wr_en_q;
   assign ub_wr_addr = wr_addr_q;
   assign ub_wr_d0   = lane0_q;
   assign ub_wr_d1   = lane1_q;
   assign ub_wr_d2   = lane2_q;
   assign ub_wr_d3   = lane3_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule
